// File: rtl/demux_8_seq_pkg.sv
// demux_8_seq_pkg: shared sizing for demux_8_seq; DEMUX8_PARITY_EN adds a ninth (odd parity) bit per frame
package demux_8_seq_pkg;
  localparam int DEMUX8_WIDTH = 8;
`ifdef DEMUX8_PARITY_EN
  localparam int DEMUX8_IDX_W = 4;
  localparam int DEMUX8_FRAME_LEN = 9;
`else
  localparam int DEMUX8_IDX_W = 3;
  localparam int DEMUX8_FRAME_LEN = 8;
`endif
endpackage

// File: rtl/demux_8_seq_if.sv
// demux_8_seq_if: serial input strobe and parallel word/status outputs of demux_8_seq
interface demux_8_seq_if;
  import demux_8_seq_pkg::*;
  logic I;
  logic V;
  logic [DEMUX8_WIDTH-1:0] O;
  logic D;
  logic B;
  logic E;
  modport master (output I, V, input O, D, B, E);
  modport slave (input I, V, output O, D, B, E);
endinterface

// File: rtl/demux_8_seq_decoder_3to8.sv
// decoder_3to8: gated 3-to-8 one-hot decoder built only from 2-input NAND primitives
module decoder_3to8 (
  input  logic [2:0] sel,
  input  logic       en,
  output logic [7:0] hot
);
  logic [2:0] sel_n;
  for (genvar b = 0; b < 3; b++) begin : g_inv
    nand u_inv (sel_n[b], sel[b], sel[b]);
  end
  for (genvar k = 0; k < 8; k++) begin : g_line
    logic l0, l1, l2, t1, t2, u1, u2, t3;
    assign l0 = k[0] ? sel[0] : sel_n[0];
    assign l1 = k[1] ? sel[1] : sel_n[1];
    assign l2 = k[2] ? sel[2] : sel_n[2];
    // four-input AND as two NAND pairs, each re-inverted, then a final NAND/invert
    nand u_t1 (t1, l0, l1);
    nand u_t2 (t2, l2, en);
    nand u_u1 (u1, t1, t1);
    nand u_u2 (u2, t2, t2);
    nand u_t3 (t3, u1, u2);
    nand u_o (hot[k], t3, t3);
  end
endmodule

// File: rtl/demux_8_seq.sv
// demux_8_seq: serial-to-8-line distributor with done pulse; DEMUX8_PARITY_EN enables 9-bit odd-parity frames
module demux_8_seq
  import demux_8_seq_pkg::*;
(
  input logic            clk,
  input logic            rst,
  demux_8_seq_if.slave   bus
);
  localparam logic [DEMUX8_IDX_W-1:0] LAST = DEMUX8_IDX_W'(DEMUX8_FRAME_LEN - 1);
  logic [DEMUX8_IDX_W-1:0] idx;
  logic [DEMUX8_WIDTH-1:0] s, s_nxt, hot, o;
  logic d, wr, last, ok;
  assign last = bus.V && idx == LAST;
`ifdef DEMUX8_PARITY_EN
  logic e;
  assign wr = bus.V && !idx[3];
  assign ok = ^{s, bus.I};
  always_ff @(posedge clk)
    if (rst) e <= 1'b0;
    else e <= last && !ok;
  assign bus.E = e;
`else
  assign wr = bus.V;
  assign ok = 1'b1;
  assign bus.E = 1'b0;
`endif
  decoder_3to8 u_dec (.sel(idx[2:0]), .en(wr), .hot(hot));
  // on the parity bit hot is zero, so s_nxt is the completed data word either way
  assign s_nxt = (s & ~hot) | (hot & {DEMUX8_WIDTH{bus.I}});
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      s <= '0;
      o <= '0;
      d <= 1'b0;
    end else begin
      s <= s_nxt;
      d <= last && ok;
      if (bus.V) idx <= last ? '0 : idx + 1'b1;
      if (last && ok) o <= s_nxt;
    end
  end
  assign bus.O = o;
  assign bus.D = d;
  assign bus.B = idx != '0;
endmodule

// File: tb/tb_demux_8_seq.sv
// tb_demux_8_seq: directed frames with hand-computed words, checked after each clock edge
module tb_demux_8_seq;
`ifdef DEMUX8_PARITY_EN
  localparam int LEN = 9;
`else
  localparam int LEN = 8;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int dcnt = 0;
  int d0;
  logic [7:0] o_exp = 8'h00;
  demux_8_seq_if bus ();
  demux_8_seq dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic i);
    @(negedge clk);
    rst = r;
    bus.V = v;
    bus.I = i;
    @(posedge clk);
    #1;
    if (bus.D === 1'b1) dcnt++;
  endtask

  task automatic idle_chk(input logic busy);
    step(1'b0, 1'b0, 1'b0);
    chk("idle_busy", bus.B, busy);
    chk("idle_done", bus.D, 0);
    chk("idle_err", bus.E, 0);
    chk("idle_word", bus.O, o_exp);
  endtask

  task automatic frame(input logic [7:0] w, input logic [7:0] gaps, input logic p);
    logic good, last, bit_in;
    good = (LEN == 8) || (^{w, p});
    for (int k = 0; k < LEN; k++) begin
      last = (k == LEN - 1);
      bit_in = (k < 8) ? w[k[2:0]] : p;
      step(1'b0, 1'b1, bit_in);
      chk("busy", bus.B, !last);
      chk("done", bus.D, last && good);
      chk("err", bus.E, last && !good);
      if (last && good) o_exp = w;
      chk("word", bus.O, o_exp);
      if (k < 8 && gaps[k[2:0]]) repeat (3) idle_chk(1'b1);
    end
  endtask

  initial begin
    bus.V = 1'b0;
    bus.I = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("rst_word", bus.O, 8'h00);
    chk("rst_done", bus.D, 0);
    chk("rst_busy", bus.B, 0);
    chk("rst_err", bus.E, 0);
    idle_chk(1'b0);

    d0 = dcnt;
    frame(8'h4D, 8'h00, 1'b1);
    idle_chk(1'b0);
    chk("f1_pulses", dcnt - d0, 1);

    d0 = dcnt;
    frame(8'h4D, 8'b0001_0010, 1'b1);
    idle_chk(1'b0);
    chk("gap_pulses", dcnt - d0, 1);

    d0 = dcnt;
    frame(8'hFF, 8'h00, 1'b1);
    frame(8'h01, 8'h00, 1'b0);
    idle_chk(1'b0);
    chk("b2b_pulses", dcnt - d0, 2);

    step(1'b1, 1'b0, 1'b0);
    o_exp = 8'h00;
    chk("rst2_word", bus.O, 8'h00);
    d0 = dcnt;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, k[0]);
      chk("abort_busy", bus.B, 1);
      chk("abort_word", bus.O, 8'h00);
    end
    step(1'b1, 1'b0, 1'b0);
    chk("abort_rst_busy", bus.B, 0);
    chk("abort_rst_word", bus.O, 8'h00);
    chk("abort_pulses", dcnt - d0, 0);
    frame(8'h3C, 8'h00, 1'b1);
    chk("post_abort_pulses", dcnt - d0, 1);

    step(1'b1, 1'b1, 1'b1);
    o_exp = 8'h00;
    chk("rstv_busy", bus.B, 0);
    chk("rstv_word", bus.O, 8'h00);
    frame(8'h81, 8'h00, 1'b1);
    idle_chk(1'b0);

`ifdef DEMUX8_PARITY_EN
    d0 = dcnt;
    frame(8'h4D, 8'h00, 1'b0);
    idle_chk(1'b0);
    chk("par_bad_word", bus.O, 8'h81);
    chk("par_bad_pulses", dcnt - d0, 0);
    frame(8'h4D, 8'h00, 1'b1);
    chk("par_good_word", bus.O, 8'h4D);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
